// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data (D) stages.
// Define MEM_ARB_STATS_EN to add per-port grant counters and an I wait-cycle counter.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_stall,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_i_grants,
    output logic [31:0]   stat_d_grants,
    output logic [31:0]   stat_i_wait
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state, state_nx;
    logic [3:0] streak;
    logic       cancel_q;
    logic       i_cand, d_cand, d_win, i_win, done;

    // A port whose ack is showing still holds its old req; keep it out of arbitration.
    always_comb begin
        i_cand   = i_req & ~i_ack;
        d_cand   = d_req & ~d_ack;
        d_win    = 1'b0;
        i_win    = 1'b0;
        done     = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                d_win = d_cand & ~(i_cand & (streak == STREAK_MAX));
                i_win = ~d_win & i_cand & ~i_cancel;
                if (d_win)      state_nx = BUSY_D;
                else if (i_win) state_nx = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                done = m_ready;
                if (m_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            streak   <= '0;
            cancel_q <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (d_win) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                streak  <= !i_req ? 4'd0 : (streak == STREAK_MAX) ? streak : streak + 4'd1;
            end else if (i_win) begin
                m_req  <= 1'b1;
                m_we   <= 1'b0;
                m_addr <= i_addr;
                streak <= '0;
            end
            // A cancelled fetch still runs to completion on the memory side, silently.
            if (done) begin
                m_req    <= 1'b0;
                cancel_q <= 1'b0;
                if (state == BUSY_D) begin
                    d_ack <= 1'b1;
                    if (!m_we) d_rdata <= m_rdata;
                end else if (!(cancel_q | i_cancel)) begin
                    i_ack   <= 1'b1;
                    i_rdata <= m_rdata;
                end
            end else if (state == BUSY_I && i_cancel) begin
                cancel_q <= 1'b1;
            end
        end
    end

    assign i_stall = rst & i_req & ~i_ack;
    assign d_stall = rst & d_req & ~d_ack;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_i_grants <= '0;
            stat_d_grants <= '0;
            stat_i_wait   <= '0;
        end else begin
            if (i_win)   stat_i_grants <= stat_i_grants + 32'd1;
            if (d_win)   stat_d_grants <= stat_d_grants + 32'd1;
            if (i_stall) stat_i_wait   <= stat_i_wait + 32'd1;
        end
    end
`endif

    // The data stage must keep its request up until the access it started is acknowledged.
    a_d_held: assert property (@(posedge clk) disable iff (!rst) (state == BUSY_D) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-port traffic against a
// word-array memory and a reference copy updated only from acknowledged transactions.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int WMAX = 3;
    localparam int TMO  = (MAXS + 2) * (WMAX + 3) + 10;

    logic          clk = 1'b0, rst = 1'b0;
    logic          i_req = 1'b0, i_cancel = 1'b0, i_ack, i_stall;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_ack, d_stall;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic          m_req, m_we, m_ready = 1'b0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   stat_i_grants, stat_d_grants, stat_i_wait;
`endif

    int total = 0, bad = 0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    int wait_n = 0, wcnt = 0;
    bit rand_wait = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_rdata(i_rdata),
        .i_ack(i_ack), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
`ifdef MEM_ARB_STATS_EN
        , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_i_wait(stat_i_wait)
`endif
    );

    always #5 clk = ~clk;

    // Memory: wait_n wait states, then m_ready for one cycle; driven on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            m_ready = 1'b0;
            wcnt    = 0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            wcnt    = 0;
        end else if (m_req) begin
            if (wcnt >= wait_n) begin
                m_ready = 1'b1;
                if (m_we) begin
                    mem[m_addr[7:0]] = m_wdata;
                    m_rdata = $urandom;
                end else begin
                    m_rdata = mem[m_addr[7:0]];
                end
                if (rand_wait) wait_n = $urandom_range(0, WMAX);
            end else begin
                wcnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_req = 1'b0; i_cancel = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic init_mem();
        for (int k = 0; k < 256; k++) begin
            mem[k]     = $urandom;
            ref_mem[k] = mem[k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        #1;
        total++;
        if ({m_req, m_we, i_ack, d_ack, i_stall, d_stall} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {m_req, m_we, i_ack, d_ack, i_stall, d_stall});
        end
        total++;
        if ({m_addr, m_wdata} !== '0) begin
            bad++; $display("FAIL reset_mbus: got %h want 0", {m_addr, m_wdata});
        end
        total++;
        if ({i_rdata, d_rdata} !== '0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_lone_fetch();
        do_reset();
        wait_n = 0;
        mem[8'h40] = 32'h2008000A; ref_mem[8'h40] = 32'h2008000A;
        i_addr = 32'h40; i_req = 1'b1;
        #1;
        total++;
        if ({i_stall, m_req} !== 2'b10) begin
            bad++; $display("FAIL lone_c0: got stall,mreq=%b want 10", {i_stall, m_req});
        end
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
            bad++; $display("FAIL lone_c1: got req=%b addr=%h we=%b want 1 40 0", m_req, m_addr, m_we);
        end
        step();
        total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h2008000A || i_stall !== 1'b0) begin
            bad++; $display("FAIL lone_c2: got ack=%b data=%h stall=%b want 1 2008000a 0", i_ack, i_rdata, i_stall);
        end
        i_req = 1'b0;
        step();
        total++;
        if (i_ack !== 1'b0 || m_req !== 1'b0) begin
            bad++; $display("FAIL lone_pulse: got ack=%b mreq=%b want 0 0", i_ack, m_req);
        end
    endtask

    task automatic test_collision();
        do_reset();
        wait_n = 0;
        i_addr = 32'h44; i_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin
            bad++; $display("FAIL coll_dgrant: got req=%b addr=%h we=%b want 1 100 0", m_req, m_addr, m_we);
        end
        step();
        total++;
        if (d_ack !== 1'b1 || d_rdata !== ref_mem[8'h00] || i_ack !== 1'b0) begin
            bad++; $display("FAIL coll_dack: got dack=%b data=%h iack=%b want 1 %h 0", d_ack, d_rdata, i_ack, ref_mem[8'h00]);
        end
        d_req = 1'b0;
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h44 || m_we !== 1'b0) begin
            bad++; $display("FAIL coll_igrant: got req=%b addr=%h we=%b want 1 44 0", m_req, m_addr, m_we);
        end
        step();
        total++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[8'h44]) begin
            bad++; $display("FAIL coll_iack: got ack=%b data=%h want 1 %h", i_ack, i_rdata, ref_mem[8'h44]);
        end
        i_req = 1'b0;
        step();
`ifdef MEM_ARB_STATS_EN
        total++;
        if (stat_d_grants !== 32'd1 || stat_i_grants !== 32'd1 || stat_i_wait !== 32'd4) begin
            bad++; $display("FAIL coll_stats: got d=%0d i=%0d wait=%0d want 1 1 4", stat_d_grants, stat_i_grants, stat_i_wait);
        end
`endif
    endtask

    // Stream k stores while a cancelled fetch sits waiting, then lift the cancel in a
    // non-ack cycle and report which port the next grant went to.
    task automatic stream_d(input int k, output logic g_req, output logic g_we,
                            output logic [AW-1:0] g_addr, output bit tmo);
        int acks = 0, cyc = 0;
        i_req = 1'b1; i_cancel = 1'b1; d_req = 1'b1; d_we = 1'b1;
        while (acks < k && cyc < 200) begin
            step();
            cyc++;
            if (d_ack) begin
                ref_mem[d_addr[7:0]] = d_wdata;
                acks++;
                d_addr  = d_addr + 32'd4;
                d_wdata = $urandom;
            end
        end
        tmo = (acks < k);
        step();
        i_cancel = 1'b0;
        step();
        g_req = m_req; g_we = m_we; g_addr = m_addr;
    endtask

    task automatic test_starvation();
        logic g_req, g_we;
        logic [AW-1:0] g_addr;
        bit tmo;
        int cyc;
        for (int n = MAXS - 1; n <= MAXS; n++) begin
            do_reset();
            wait_n = 0;
            i_addr = 32'h60; d_addr = 32'h80; d_wdata = $urandom;
            stream_d(n, g_req, g_we, g_addr, tmo);
            total++;
            if (n >= MAXS) begin
                if (tmo || g_req !== 1'b1 || g_we !== 1'b0 || g_addr !== 32'h60) begin
                    bad++; $display("FAIL starve_limit n=%0d: got req=%b we=%b addr=%h tmo=%0d want I grant at 60", n, g_req, g_we, g_addr, tmo);
                end
            end else begin
                if (tmo || g_req !== 1'b1 || g_we !== 1'b1 || g_addr !== d_addr) begin
                    bad++; $display("FAIL starve_below n=%0d: got req=%b we=%b addr=%h tmo=%0d want D grant at %h", n, g_req, g_we, g_addr, tmo, d_addr);
                end
            end
        end
        cyc = 0;
        while (!i_ack && cyc < TMO) begin
            step();
            cyc++;
        end
        total++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[8'h60]) begin
            bad++; $display("FAIL starve_iack: got ack=%b data=%h want 1 %h", i_ack, i_rdata, ref_mem[8'h60]);
        end
        // After the I grant the streak restarts, so one D grant no longer blocks D.
        stream_d(1, g_req, g_we, g_addr, tmo);
        total++;
        if (tmo || g_req !== 1'b1 || g_we !== 1'b1 || g_addr !== d_addr) begin
            bad++; $display("FAIL starve_cleared: got req=%b we=%b addr=%h tmo=%0d want D grant at %h", g_req, g_we, g_addr, tmo, d_addr);
        end
    endtask

    task automatic test_cancel();
        bit ack_seen = 1'b0;
        do_reset();
        wait_n = 0;
        i_addr = 32'h4C; i_req = 1'b1;
        step(); step();
        total++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[8'h4C]) begin
            bad++; $display("FAIL cancel_pre: got ack=%b data=%h want 1 %h", i_ack, i_rdata, ref_mem[8'h4C]);
        end
        i_req = 1'b0;
        step();
        wait_n = 3;
        i_addr = 32'h48; i_req = 1'b1;
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h48) begin
            bad++; $display("FAIL cancel_grant: got req=%b addr=%h want 1 48", m_req, m_addr);
        end
        i_cancel = 1'b1; i_req = 1'b0;
        step();
        i_cancel = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            if (c <= 4) begin
                total++;
                if (m_req !== 1'b1 || m_addr !== 32'h48) begin
                    bad++; $display("FAIL cancel_hold c%0d: got req=%b addr=%h want 1 48", c, m_req, m_addr);
                end
            end else if (c == 5) begin
                total++;
                if (m_req !== 1'b0) begin
                    bad++; $display("FAIL cancel_done: got req=%b want 0", m_req);
                end
            end
            if (i_ack) ack_seen = 1'b1;
            step();
        end
        total++;
        if (ack_seen || i_rdata !== ref_mem[8'h4C]) begin
            bad++; $display("FAIL cancel_quiet: got ack_seen=%0d data=%h want 0 %h", ack_seen, i_rdata, ref_mem[8'h4C]);
        end
        wait_n = 0;
        i_addr = 32'h50; i_req = 1'b1;
        step(); step();
        total++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[8'h50]) begin
            bad++; $display("FAIL cancel_after: got ack=%b data=%h want 1 %h", i_ack, i_rdata, ref_mem[8'h50]);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_n = 3;
        d_addr = 32'h10; d_we = 1'b0; d_req = 1'b1;
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h10) begin
            bad++; $display("FAIL rmid_grant: got req=%b addr=%h want 1 10", m_req, m_addr);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({m_req, d_ack, d_stall, i_ack} !== 4'b0 || m_addr !== '0) begin
            bad++; $display("FAIL rmid_clear: got ctl=%b addr=%h want 0000 0", {m_req, d_ack, d_stall, i_ack}, m_addr);
        end
        d_req = 1'b0;
        step(); step();
        rst = 1'b1;
        wait_n = 0;
        i_addr = 32'h14; i_req = 1'b1;
        step();
        total++;
        if (m_req !== 1'b1 || m_addr !== 32'h14 || m_we !== 1'b0) begin
            bad++; $display("FAIL rmid_idle: got req=%b addr=%h we=%b want 1 14 0", m_req, m_addr, m_we);
        end
        step();
        total++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[8'h14]) begin
            bad++; $display("FAIL rmid_fetch: got ack=%b data=%h want 1 %h", i_ack, i_rdata, ref_mem[8'h14]);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic i_port(input int n);
        logic [AW-1:0] a;
        int cyc;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            a = $urandom; a[7] = 1'b0;
            i_addr = a; i_req = 1'b1;
            cyc = 0;
            do begin step(); cyc++; end while (!i_ack && cyc < TMO);
            total++;
            if (i_ack !== 1'b1 || i_rdata !== ref_mem[a[7:0]]) begin
                bad++; $display("FAIL rand_fetch %h: got ack=%b data=%h want 1 %h", a, i_ack, i_rdata, ref_mem[a[7:0]]);
            end
            i_req = 1'b0;
            step();
            total++;
            if (i_ack !== 1'b0) begin
                bad++; $display("FAIL rand_ipulse: got ack=%b want 0", i_ack);
            end
        end
    endtask

    task automatic d_port(input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] last_d = '0, want;
        logic st;
        int cyc;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            a = $urandom; a[7] = 1'b1;
            st = 1'($urandom_range(0, 1));
            d_addr = a; d_we = st; d_wdata = $urandom; d_req = 1'b1;
            cyc = 0;
            do begin step(); cyc++; end while (!d_ack && cyc < TMO);
            want = st ? last_d : ref_mem[a[7:0]];
            if (st) ref_mem[a[7:0]] = d_wdata;
            else    last_d = want;
            total++;
            if (d_ack !== 1'b1 || d_rdata !== want) begin
                bad++; $display("FAIL rand_data %h we=%b: got ack=%b data=%h want 1 %h", a, st, d_ack, d_rdata, want);
            end
            d_req = 1'b0;
            step();
            total++;
            if (d_ack !== 1'b0) begin
                bad++; $display("FAIL rand_dpulse: got ack=%b want 0", d_ack);
            end
        end
    endtask

    task automatic test_random();
        init_mem();
        do_reset();
        rand_wait = 1'b1;
        fork
            i_port(40);
            d_port(40);
        join
        rand_wait = 1'b0;
        wait_n = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        init_mem();
        test_reset();
        test_lone_fetch();
        test_collision();
        test_starvation();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
